// File: rtl/spu32_cpu_trapunit_if.sv
// Core <-> trap unit signal bundle: pulses, CSR access port and trap target outputs.
interface spu32_cpu_trapunit_if #(
    parameter int NUM_IRQ = 4
);
    logic [NUM_IRQ-1:0] I_irq;
    logic               I_trap_req;
    logic [3:0]         I_trap_cause;
    logic               I_irq_ack;
    logic               I_mret;
    logic [29:0]        I_pc;
    logic [2:0]         I_csr_sel;
    logic               I_csr_we;
    logic [31:0]        I_csr_wdata;
    logic [31:0]        O_csr_rdata;
    logic               O_irq_pending;
    logic [29:0]        O_vector;
    logic [29:0]        O_epc;

    modport master (
        output I_irq, I_trap_req, I_trap_cause, I_irq_ack, I_mret, I_pc,
               I_csr_sel, I_csr_we, I_csr_wdata,
        input  O_csr_rdata, O_irq_pending, O_vector, O_epc
    );

    modport slave (
        input  I_irq, I_trap_req, I_trap_cause, I_irq_ack, I_mret, I_pc,
               I_csr_sel, I_csr_we, I_csr_wdata,
        output O_csr_rdata, O_irq_pending, O_vector, O_epc
    );
endinterface

// File: rtl/spu32_cpu_trapunit.sv
// spu32 trap/interrupt controller with NUM_IRQ prioritised maskable lines.
// Define SPU32_TRAPUNIT_VECTORED_EN to dispatch interrupts to evect + mcause code.
module spu32_cpu_trapunit #(
    parameter int          NUM_IRQ          = 4,
    parameter logic [31:0] VECTOR_EXCEPTION = 32'd16
) (
    input  logic                    I_clk,
    input  logic                    I_reset,
    spu32_cpu_trapunit_if.slave     bus
);
    logic               mie_q, mie_d;
    logic               mpie_q, mpie_d;
    logic               mcause_intr_q, mcause_intr_d;
    logic [4:0]         mcause_code_q, mcause_code_d;
    logic [29:0]        epc_q, epc_d;
    logic [29:0]        evect_q, evect_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] mip_q;
    logic [3:0]         win_idx_q, win_idx_d;
    logic               pending_s;
    logic [NUM_IRQ-1:0] req_s;
    logic [31:0]        rdata_s;
    logic [29:0]        vector_s;

    assign pending_s = mie_q & (|(mip_q & mask_q));
    assign req_s     = bus.I_irq & mask_q;

    // Priority encoder: lowest set index of the masked request lines wins.
    always_comb begin
        win_idx_d = 4'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            win_idx_d = req_s[i] ? 4'(i) : win_idx_d;
        end
    end

    // Next-state for the machine state registers; one pulse acts per cycle.
    always_comb begin
        mie_d         = mie_q;
        mpie_d        = mpie_q;
        mcause_intr_d = mcause_intr_q;
        mcause_code_d = mcause_code_q;
        epc_d         = epc_q;
        evect_d       = evect_q;
        mask_d        = mask_q;
        if (bus.I_trap_req) begin
            mcause_intr_d = 1'b0;
            mcause_code_d = {1'b0, bus.I_trap_cause};
            epc_d         = bus.I_pc;
            mpie_d        = mie_q;
            mie_d         = 1'b0;
        end else if (bus.I_irq_ack && pending_s) begin
            mcause_intr_d = 1'b1;
            mcause_code_d = {1'b1, win_idx_q};
            epc_d         = bus.I_pc;
            mpie_d        = mie_q;
            mie_d         = 1'b0;
        end else if (bus.I_mret) begin
            mie_d         = mpie_q;
            mcause_intr_d = 1'b0;
            mcause_code_d = 5'd0;
        end else if (bus.I_csr_we) begin
            case (bus.I_csr_sel)
                3'd0: begin
                    mie_d  = bus.I_csr_wdata[0];
                    mpie_d = bus.I_csr_wdata[1];
                end
                3'd1: begin
                    mcause_intr_d = bus.I_csr_wdata[31];
                    mcause_code_d = bus.I_csr_wdata[4:0];
                end
                3'd2:    epc_d   = bus.I_csr_wdata[31:2];
                3'd3:    evect_d = bus.I_csr_wdata[31:2];
                3'd4:    mask_d  = bus.I_csr_wdata[NUM_IRQ-1:0];
                default: mask_d  = mask_q;
            endcase
        end else begin
            mie_d = mie_q;
        end
    end

    // State registers advance on the falling edge, in step with the core FSM.
    always_ff @(negedge I_clk) begin
        if (I_reset) begin
            mie_q         <= 1'b0;
            mpie_q        <= 1'b0;
            mcause_intr_q <= 1'b0;
            mcause_code_q <= 5'd0;
            epc_q         <= 30'd0;
            evect_q       <= VECTOR_EXCEPTION[31:2];
            mask_q        <= {NUM_IRQ{1'b0}};
            mip_q         <= {NUM_IRQ{1'b0}};
            win_idx_q     <= 4'd0;
        end else begin
            mie_q         <= mie_d;
            mpie_q        <= mpie_d;
            mcause_intr_q <= mcause_intr_d;
            mcause_code_q <= mcause_code_d;
            epc_q         <= epc_d;
            evect_q       <= evect_d;
            mask_q        <= mask_d;
            mip_q         <= bus.I_irq;
            win_idx_q     <= win_idx_d;
        end
    end

    // CSR read mux; reflects pre-edge state so a same-cycle write reads old data.
    always_comb begin
        case (bus.I_csr_sel)
            3'd0:    rdata_s = {29'd0, |mip_q, mpie_q, mie_q};
            3'd1:    rdata_s = {mcause_intr_q, 26'd0, mcause_code_q};
            3'd2:    rdata_s = {epc_q, 2'b00};
            3'd3:    rdata_s = {evect_q, 2'b00};
            3'd4:    rdata_s = {{(32 - NUM_IRQ){1'b0}}, mask_q};
            3'd5:    rdata_s = {{(32 - NUM_IRQ){1'b0}}, mip_q};
            default: rdata_s = 32'd0;
        endcase
    end

`ifdef SPU32_TRAPUNIT_VECTORED_EN
    // Interrupt code is 16 + winning line, so it doubles as the word offset.
    assign vector_s = mcause_intr_q ? (evect_q + {25'd0, mcause_code_q}) : evect_q;
`else
    assign vector_s = evect_q;
`endif

    assign bus.O_csr_rdata   = rdata_s;
    assign bus.O_irq_pending = pending_s;
    assign bus.O_vector      = vector_s;
    assign bus.O_epc         = epc_q;
endmodule

// File: tb/tb_spu32_cpu_trapunit.sv
// Self-checking bench for spu32_cpu_trapunit: directed scenarios plus randomized
// pulses compared against a byte-address level reference model.
module tb_spu32_cpu_trapunit;
    localparam int NQ = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    spu32_cpu_trapunit_if #(.NUM_IRQ(NQ)) bus ();

    spu32_cpu_trapunit #(.NUM_IRQ(NQ), .VECTOR_EXCEPTION(32'd16)) dut (
        .I_clk   (clk),
        .I_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference model: architectural registers kept as full 32-bit values.
    bit          m_mie, m_mpie;
    bit [31:0]   m_mcause, m_epc, m_evect;
    bit [NQ-1:0] m_mask, m_mip;
    int          m_win;

    function automatic int lowest(input bit [NQ-1:0] v);
        for (int i = 0; i < NQ; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic bit m_pend();
        return m_mie && ((m_mip & m_mask) != 0);
    endfunction

    function automatic bit [31:0] m_read(input int sel);
        case (sel)
            0: return {29'd0, (m_mip != 0), m_mpie, m_mie};
            1: return m_mcause;
            2: return m_epc;
            3: return m_evect;
            4: return 32'(m_mask);
            5: return 32'(m_mip);
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit [29:0] m_vec();
        bit [31:0] b;
        b = m_evect;
`ifdef SPU32_TRAPUNIT_VECTORED_EN
        if (m_mcause[31]) b = m_evect + ((m_mcause & 32'd31) * 32'd4);
`endif
        return b[31:2];
    endfunction

    task automatic m_edge();
        int        nwin;
        bit [31:0] wd;
        if (rst) begin
            m_mie = 0; m_mpie = 0; m_mcause = 0; m_epc = 0; m_evect = 32'd16;
            m_mask = 0; m_mip = 0; m_win = 0;
            return;
        end
        nwin = lowest(bus.I_irq & m_mask);
        wd   = bus.I_csr_wdata;
        if (bus.I_trap_req) begin
            m_mcause = 32'(bus.I_trap_cause);
            m_epc = {bus.I_pc, 2'b00}; m_mpie = m_mie; m_mie = 0;
        end else if (bus.I_irq_ack && m_pend()) begin
            m_mcause = 32'h8000_0000 | 32'(16 + m_win);
            m_epc = {bus.I_pc, 2'b00}; m_mpie = m_mie; m_mie = 0;
        end else if (bus.I_mret) begin
            m_mie = m_mpie; m_mcause = 0;
        end else if (bus.I_csr_we) begin
            case (bus.I_csr_sel)
                3'd0: begin m_mie = wd[0]; m_mpie = wd[1]; end
                3'd1: m_mcause = wd & 32'h8000_001F;
                3'd2: m_epc = wd & 32'hFFFF_FFFC;
                3'd3: m_evect = wd & 32'hFFFF_FFFC;
                3'd4: m_mask = wd[NQ-1:0];
                default: ;
            endcase
        end
        m_mip = bus.I_irq;
        m_win = nwin;
    endtask

    task automatic tick();
        m_edge();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic clr_pulses();
        bus.I_trap_req = 0; bus.I_irq_ack = 0; bus.I_mret = 0; bus.I_csr_we = 0;
    endtask

    task automatic rd(input int sel, output logic [31:0] d);
        bus.I_csr_sel = 3'(sel);
        #1;
        d = bus.O_csr_rdata;
    endtask

    task automatic csr_wr(input int sel, input logic [31:0] d);
        bus.I_csr_sel = 3'(sel); bus.I_csr_wdata = d; bus.I_csr_we = 1;
        tick();
        clr_pulses();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        bus.I_irq = '1; bus.I_trap_req = 1; bus.I_trap_cause = 4'd11;
        bus.I_irq_ack = 1; bus.I_mret = 1; bus.I_pc = 30'h3FF;
        rst = 1;
        tick(); tick();
        rst = 0; clr_pulses(); bus.I_irq = '0;
        for (int s = 0; s < 8; s++) begin
            rd(s, d);
            checks++;
            if (d !== ((s == 3) ? 32'h10 : 32'h0)) begin
                errors++; $display("FAIL reset_csr sel=%0d actual=%h expected=%h", s, d, (s == 3) ? 32'h10 : 32'h0);
            end
        end
        checks++;
        if (bus.O_irq_pending !== 1'b0 || bus.O_epc !== 30'd0 || bus.O_vector !== 30'h4) begin
            errors++; $display("FAIL reset_outs actual=%b/%h/%h expected=0/0/4", bus.O_irq_pending, bus.O_epc, bus.O_vector);
        end
    endtask

    task automatic test_irq_entry();
        logic [31:0] d;
        csr_wr(4, 32'h6);
        csr_wr(0, 32'h1);
        checks++;
        if (bus.O_irq_pending !== 1'b0) begin errors++; $display("FAIL pend_early actual=%b expected=0", bus.O_irq_pending); end
        bus.I_irq = 4'b0110;
        tick();
        checks++;
        if (bus.O_irq_pending !== 1'b1) begin errors++; $display("FAIL pend_rise actual=%b expected=1", bus.O_irq_pending); end
        bus.I_pc = 30'h10; bus.I_irq_ack = 1;
        tick(); clr_pulses();
        rd(1, d); checks++;
        if (d !== 32'h8000_0011) begin errors++; $display("FAIL irq_mcause actual=%h expected=80000011", d); end
        rd(2, d); checks++;
        if (d !== 32'h40) begin errors++; $display("FAIL irq_epc actual=%h expected=00000040", d); end
        rd(0, d); checks++;
        if (d !== 32'h6) begin errors++; $display("FAIL irq_mstatus actual=%h expected=00000006", d); end
        checks++;
        if (bus.O_irq_pending !== 1'b0) begin errors++; $display("FAIL irq_nested actual=%b expected=0", bus.O_irq_pending); end
    endtask

    task automatic test_trap_vs_ack();
        logic [31:0] d;
        csr_wr(0, 32'h1);
        bus.I_trap_req = 1; bus.I_trap_cause = 4'd11; bus.I_irq_ack = 1; bus.I_pc = 30'h20;
        tick(); clr_pulses();
        rd(1, d); checks++;
        if (d !== 32'h0000_000B) begin errors++; $display("FAIL trap_mcause actual=%h expected=0000000b", d); end
        rd(5, d); checks++;
        if (d !== 32'h6) begin errors++; $display("FAIL trap_mip actual=%h expected=00000006", d); end
        rd(2, d); checks++;
        if (d !== 32'h80) begin errors++; $display("FAIL trap_epc actual=%h expected=00000080", d); end
        checks++;
        if (bus.O_vector !== 30'h4) begin errors++; $display("FAIL trap_vector actual=%h expected=4", bus.O_vector); end
    endtask

    task automatic test_mret();
        logic [31:0] d;
        bus.I_mret = 1;
        tick(); clr_pulses();
        rd(1, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL mret_mcause actual=%h expected=0", d); end
        rd(0, d); checks++;
        if (d !== 32'h7) begin errors++; $display("FAIL mret_mstatus actual=%h expected=7", d); end
        checks++;
        if (bus.O_epc !== 30'h20 || bus.O_irq_pending !== 1'b1) begin
            errors++; $display("FAIL mret_epc_pend actual=%h/%b expected=20/1", bus.O_epc, bus.O_irq_pending);
        end
    endtask

    task automatic test_mask_drop();
        logic [31:0] d;
        bus.I_irq = 4'b0001;
        csr_wr(4, 32'h1);
        checks++;
        if (bus.O_irq_pending !== 1'b1) begin errors++; $display("FAIL mask_pend actual=%b expected=1", bus.O_irq_pending); end
        csr_wr(4, 32'h0);
        checks++;
        if (bus.O_irq_pending !== 1'b0) begin errors++; $display("FAIL mask_fall actual=%b expected=0", bus.O_irq_pending); end
        bus.I_irq_ack = 1; bus.I_pc = 30'h3F;
        tick(); clr_pulses();
        for (int s = 0; s < 6; s++) begin
            rd(s, d); checks++;
            if (d !== m_read(s)) begin errors++; $display("FAIL late_ack sel=%0d actual=%h expected=%h", s, d, m_read(s)); end
        end
        checks++;
        if (bus.O_epc !== 30'h20) begin errors++; $display("FAIL late_ack_epc actual=%h expected=20", bus.O_epc); end
    endtask

    task automatic test_irq_drop();
        logic [31:0] d;
        csr_wr(4, 32'h1);
        bus.I_irq = 4'b0000;
        tick();
        checks++;
        if (bus.O_irq_pending !== 1'b0) begin errors++; $display("FAIL drop_pend actual=%b expected=0", bus.O_irq_pending); end
        bus.I_irq_ack = 1;
        tick(); clr_pulses();
        rd(1, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL drop_ack actual=%h expected=0", d); end
    endtask

    task automatic test_vectored();
        logic [29:0] exp_v;
`ifdef SPU32_TRAPUNIT_VECTORED_EN
        exp_v = 30'h52;
`else
        exp_v = 30'h40;
`endif
        csr_wr(3, 32'h100);
        csr_wr(4, 32'h4);
        bus.I_irq = 4'b0100;
        tick();
        bus.I_irq_ack = 1; bus.I_pc = 30'h1;
        tick(); clr_pulses();
        checks++;
        if (bus.O_vector !== exp_v) begin errors++; $display("FAIL vec_irq actual=%h expected=%h", bus.O_vector, exp_v); end
        bus.I_trap_req = 1; bus.I_trap_cause = 4'd2;
        tick(); clr_pulses();
        checks++;
        if (bus.O_vector !== 30'h40) begin errors++; $display("FAIL vec_exc actual=%h expected=40", bus.O_vector); end
        bus.I_irq = '0;
    endtask

    task automatic test_random();
        logic [31:0] d;
        int sel;
        for (int n = 0; n < 600; n++) begin
            rst               = ($urandom_range(0, 99) == 0);
            bus.I_irq         = NQ'($urandom_range(0, 15));
            bus.I_trap_req    = ($urandom_range(0, 9) == 0);
            bus.I_trap_cause  = 4'($urandom);
            bus.I_irq_ack     = ($urandom_range(0, 3) == 0);
            bus.I_mret        = ($urandom_range(0, 7) == 0);
            bus.I_pc          = 30'($urandom);
            bus.I_csr_we      = ($urandom_range(0, 2) == 0);
            bus.I_csr_wdata   = $urandom;
            if ($urandom_range(0, 1) == 0) bus.I_csr_wdata[0] = 1'b1;
            sel = $urandom_range(0, 7);
            rd(sel, d); checks++;
            if (d !== m_read(sel)) begin errors++; $display("FAIL rnd_csr n=%0d sel=%0d actual=%h expected=%h", n, sel, d, m_read(sel)); end
            tick();
            checks++;
            if (bus.O_irq_pending !== m_pend() || bus.O_epc !== m_epc[31:2] || bus.O_vector !== m_vec()) begin
                errors++;
                $display("FAIL rnd_outs n=%0d actual=%b/%h/%h expected=%b/%h/%h", n, bus.O_irq_pending, bus.O_epc,
                         bus.O_vector, m_pend(), m_epc[31:2], m_vec());
            end
        end
        rst = 0; clr_pulses();
    endtask

    initial begin
        bus.I_irq = '0; bus.I_trap_cause = 4'd0; bus.I_pc = 30'd0;
        bus.I_csr_sel = 3'd0; bus.I_csr_wdata = 32'd0;
        clr_pulses();
        @(posedge clk); #1;
        test_reset();
        test_irq_entry();
        test_trap_vs_ack();
        test_mret();
        test_mask_drop();
        test_irq_drop();
        test_vectored();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
